multi_channel_frame_framer: RTL and testbench

- Merges NCH payload streams into NCH output streams, arbitrated beat-by-beat.
- Frame = FRAME_BEATS payload beats, then META_BEATS metadata beats (optional), then one trailer beat carrying a running frame number.
- Metadata and trailer are broadcast to all outputs; trailer carries tlast.
- Sits between packet sources and the per-path DMA/Ethernet egress; full AXI-Stream backpressure on every interface.

---
 rtl/multi_channel_frame_framer.sv | 120 ++++++++++++
 tb/tb_multi_channel_frame_framer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_frame_framer.sv
// multi_channel_frame_framer: arbitrates NCH payload streams into framed outputs with broadcast metadata and a numbered trailer.
module multi_channel_frame_framer #(
  parameter int DW          = 128,
  parameter int NCH         = 2,
  parameter int FRAME_BEATS = 128,
  parameter int META_BEATS  = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  md_enable,
  input  logic [NCH*DW-1:0]     s_tdata,
  input  logic [NCH-1:0]        s_tvalid,
  output logic [NCH-1:0]        s_tready,
  input  logic [DW-1:0]         s_meta_tdata,
  input  logic                  s_meta_tvalid,
  output logic                  s_meta_tready,
  output logic [NCH*DW-1:0]     m_tdata,
  output logic [NCH-1:0]        m_tvalid,
  input  logic [NCH-1:0]        m_tready,
  output logic [NCH-1:0]        m_tlast,
  output logic [NCH*DW/8-1:0]   m_tkeep,
  output logic [CNT_W-1:0]      frame_num,
  output logic [1:0]            state
);
  localparam int KW = DW / 8;
  localparam int BW = FRAME_BEATS > 1 ? $clog2(FRAME_BEATS) : 1;
  localparam int MW = META_BEATS > 1 ? $clog2(META_BEATS) : 1;
  localparam int GW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {PAYLOAD = 2'd0, META = 2'd1, TRAILER = 2'd2} state_t;
  state_t            r_state;
  logic [BW-1:0]     r_beat;
  logic [MW-1:0]     r_meta;
  logic [CNT_W-1:0]  r_frame_num;
  logic              r_hold;
  logic [GW-1:0]     r_gnt;
  logic [GW-1:0]     w_low;
  logic [GW-1:0]     w_gnt;
  logic              w_any;
  logic              w_all_rdy;
  logic              w_pay_done;
  logic              w_meta_done;
  logic              w_trl_done;
  always_comb begin
    w_low = '0;
    for (int i = NCH - 1; i >= 0; i--) if (s_tvalid[i]) w_low = GW'(i);
  end
  // a stalled beat keeps its channel even if a lower index becomes valid
  assign w_gnt       = (r_hold && s_tvalid[r_gnt]) ? r_gnt : w_low;
  assign w_any       = |s_tvalid;
  assign w_all_rdy   = &m_tready;
  assign w_pay_done  = r_state == PAYLOAD && w_any && m_tready[w_gnt];
  assign w_meta_done = r_state == META && md_enable && s_meta_tvalid && w_all_rdy;
  assign w_trl_done  = r_state == TRAILER && w_all_rdy;
  assign frame_num   = r_frame_num;
  assign state       = r_state;
  always_comb begin
    m_tdata       = '0;
    m_tvalid      = '0;
    m_tlast       = '0;
    m_tkeep       = '0;
    s_tready      = '0;
    s_meta_tready = 1'b0;
    if (resetn) begin
      if (r_state == PAYLOAD && w_any) begin
        m_tdata[w_gnt*DW +: DW] = s_tdata[w_gnt*DW +: DW];
        m_tvalid[w_gnt]         = 1'b1;
        m_tkeep[w_gnt*KW +: KW] = '1;
        s_tready[w_gnt]         = m_tready[w_gnt];
      end else if (r_state == META) begin
        m_tdata       = {NCH{s_meta_tdata}};
        m_tvalid      = {NCH{s_meta_tvalid & md_enable}};
        m_tkeep       = '1;
        s_meta_tready = md_enable & w_all_rdy;
      end else if (r_state == TRAILER) begin
        m_tdata  = {NCH{DW'(r_frame_num)}};
        m_tvalid = '1;
        m_tlast  = '1;
        m_tkeep  = '1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= PAYLOAD;
      r_beat      <= '0;
      r_meta      <= '0;
      r_frame_num <= '0;
      r_hold      <= 1'b0;
      r_gnt       <= '0;
    end else begin
      r_hold <= 1'b0;
      case (r_state)
        PAYLOAD: begin
          r_hold <= w_any && !m_tready[w_gnt];
          r_gnt  <= w_gnt;
          if (w_pay_done) begin
            r_beat <= r_beat == BW'(FRAME_BEATS - 1) ? '0 : r_beat + 1'b1;
            if (r_beat == BW'(FRAME_BEATS - 1)) r_state <= md_enable ? META : TRAILER;
          end
        end
        META: begin
          if (!md_enable || (w_meta_done && r_meta == MW'(META_BEATS - 1))) begin
            r_meta  <= '0;
            r_state <= TRAILER;
          end else if (w_meta_done) begin
            r_meta <= r_meta + 1'b1;
          end
        end
        TRAILER: begin
          if (w_trl_done) begin
            r_frame_num <= r_frame_num + 1'b1;
            r_state     <= PAYLOAD;
          end
        end
        default: r_state <= PAYLOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_channel_frame_framer.sv
// tb_multi_channel_frame_framer: directed and random scenarios against a frame-position reference model.
module tb_multi_channel_frame_framer;
  localparam int DW = 32, NCH = 2, FB = 4, MB = 2, CW = 4, KW = DW / 8;
  localparam int OW = NCH*DW + 3*NCH + NCH*KW + 1 + CW + 2;
  logic clk = 1'b0;
  logic resetn, md_enable, s_meta_tvalid, s_meta_tready;
  logic [NCH*DW-1:0] s_tdata, m_tdata;
  logic [NCH-1:0] s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
  logic [NCH*KW-1:0] m_tkeep;
  logic [DW-1:0] s_meta_tdata;
  logic [CW-1:0] frame_num;
  logic [1:0] state;
  int total = 0, bad = 0;
  int pos = 0, fn = 0, hold = -1;
  logic [OW-1:0] exp_v;
  always #5 clk = ~clk;
  multi_channel_frame_framer #(.DW(DW), .NCH(NCH), .FRAME_BEATS(FB), .META_BEATS(MB), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .md_enable(md_enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_meta_tdata(s_meta_tdata), .s_meta_tvalid(s_meta_tvalid), .s_meta_tready(s_meta_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tkeep(m_tkeep), .frame_num(frame_num), .state(state)
  );
  function automatic logic [OW-1:0] obs_v();
    return {m_tdata, m_tvalid, m_tlast, m_tkeep, s_tready, s_meta_tready, frame_num, state};
  endfunction
  // pos walks the frame: 0..FB-1 payload, FB..FB+MB-1 metadata, FB+MB trailer
  task automatic model_step();
    logic [NCH*DW-1:0] d;
    logic [NCH-1:0] v, l, r;
    logic [NCH*KW-1:0] k;
    logic mr;
    logic [1:0] st;
    int g, fn0;
    d = '0; v = '0; l = '0; r = '0; k = '0; mr = 1'b0; g = -1; fn0 = fn;
    st = pos < FB ? 2'd0 : pos < FB + MB ? 2'd1 : 2'd2;
    if (!resetn) begin
      d = '0; v = '0;
      pos = 0; fn = 0; hold = -1;
    end else if (pos < FB) begin
      if (hold >= 0 && s_tvalid[hold]) g = hold;
      else for (int i = NCH - 1; i >= 0; i--) if (s_tvalid[i]) g = i;
      hold = -1;
      if (g >= 0) begin
        d[g*DW +: DW] = s_tdata[g*DW +: DW];
        v[g] = 1'b1;
        k[g*KW +: KW] = '1;
        r[g] = m_tready[g];
        if (m_tready[g]) begin
          pos++;
          if (pos == FB && !md_enable) pos = FB + MB;
        end else hold = g;
      end
    end else if (pos < FB + MB) begin
      d = {NCH{s_meta_tdata}};
      k = '1;
      if (!md_enable) pos = FB + MB;
      else begin
        v = {NCH{s_meta_tvalid}};
        mr = &m_tready;
        if (s_meta_tvalid && mr) pos++;
      end
    end else begin
      v = '1; l = '1; k = '1;
      d = {NCH{DW'(fn)}};
      if (&m_tready) begin
        fn = (fn + 1) % (1 << CW);
        pos = 0;
      end
    end
    exp_v = {d, v, l, k, r, mr, CW'(fn0), st};
  endtask
  task automatic eval_cyc();
    @(negedge clk);
    model_step();
  endtask
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    resetn = 1'b0; md_enable = 1'b1; s_tvalid = '1; s_tdata = '1;
    s_meta_tvalid = 1'b1; s_meta_tdata = '1; m_tready = '1;
    next_cyc();
    for (int c = 0; c < 3; c++) begin
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL reset_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      total++;
      if (m_tvalid !== '0 || s_tready !== '0 || m_tdata !== '0 || s_meta_tready !== 1'b0 || state !== 2'd0) begin
        bad++; $display("FAIL reset_outputs c=%0d got vld=%b rdy=%b st=%0d want all 0", c, m_tvalid, s_tready, state);
      end
      next_cyc();
    end
    resetn = 1'b1; s_tvalid = '0; s_meta_tvalid = 1'b0;
  endtask
  task automatic test_basic_frame();
    md_enable = 1'b1; m_tready = '1; s_tvalid = 2'b01; s_meta_tvalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_tdata = {DW'(32'hB0 + i), DW'(32'hA0 + i)};
      s_meta_tdata = DW'(32'hE0 + i);
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL basic_model i=%0d got=%h want=%h", i, obs_v(), exp_v); end
      if (i == 4) begin
        total++;
        if (m_tdata !== {2{32'hE4}}) begin bad++; $display("FAIL basic_meta got=%h want=%h", m_tdata, {2{32'hE4}}); end
      end
      if (i == 6) begin
        total++;
        if (m_tdata !== '0 || m_tlast !== 2'b11) begin bad++; $display("FAIL basic_trailer got data=%h last=%b want 0/11", m_tdata, m_tlast); end
      end
      next_cyc();
    end
    s_tvalid = '0;
    eval_cyc();
    total++;
    if (frame_num !== CW'(1)) begin bad++; $display("FAIL basic_frame_num got=%0d want=1", frame_num); end
    next_cyc();
  endtask
  task automatic test_priority();
    md_enable = 1'b0; m_tready = '1; s_tvalid = 2'b11; s_tdata = {32'h22, 32'h11};
    for (int c = 0; c < 2; c++) begin
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL prio_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      total++;
      if (s_tready !== 2'b01 || m_tdata[DW +: DW] !== '0) begin bad++; $display("FAIL prio_stall got rdy=%b want 01", s_tready); end
      next_cyc();
    end
    s_tvalid = 2'b10;
    eval_cyc();
    total++;
    if (obs_v() !== exp_v) begin bad++; $display("FAIL prio_model_sw got=%h want=%h", obs_v(), exp_v); end
    total++;
    if (m_tdata[DW +: DW] !== 32'h22 || m_tvalid !== 2'b10) begin
      bad++; $display("FAIL prio_switch got data=%h vld=%b want 22/10", m_tdata[DW +: DW], m_tvalid);
    end
    next_cyc();
  endtask
  task automatic test_no_meta();
    md_enable = 1'b0; m_tready = '1; s_tvalid = 2'b01; s_meta_tvalid = 1'b1; s_meta_tdata = 32'h5A5A;
    for (int c = 0; c < 6; c++) begin
      s_tdata = {$urandom, $urandom};
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL nometa_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      total++;
      if (s_meta_tready !== 1'b0 || state === 2'd1) begin bad++; $display("FAIL nometa_skip got mrdy=%b st=%0d want 0/not1", s_meta_tready, state); end
      next_cyc();
    end
  endtask
  task automatic test_trailer_hold();
    int fn0, held;
    md_enable = 1'b0; m_tready = '1; s_tvalid = 2'b01;
    for (int c = 0; c < 20 && pos != FB + MB; c++) begin
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL hold_pre_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      next_cyc();
    end
    fn0 = fn; held = 0;
    m_tready = 2'b01;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) m_tready = 2'b11;
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL hold_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      if (m_tlast === 2'b11 && m_tvalid === 2'b11 && frame_num === CW'(fn0)) held++;
      next_cyc();
    end
    total++;
    if (held != 4) begin bad++; $display("FAIL hold_cycles got=%0d want=4", held); end
    eval_cyc();
    total++;
    if (frame_num !== CW'(fn0 + 1) || state !== 2'd0) begin bad++; $display("FAIL hold_incr got fn=%0d st=%0d want %0d/0", frame_num, state, CW'(fn0 + 1)); end
    next_cyc();
  endtask
  task automatic test_wrap();
    int ntr;
    resetn = 1'b0;
    eval_cyc();
    total++;
    if (obs_v() !== exp_v) begin bad++; $display("FAIL wrap_rst_model got=%h want=%h", obs_v(), exp_v); end
    next_cyc();
    resetn = 1'b1; m_tready = '1; s_tvalid = '1; s_meta_tvalid = 1'b1; ntr = 0;
    for (int c = 0; c < 400 && ntr < 17; c++) begin
      s_tdata = {$urandom, $urandom};
      s_meta_tdata = $urandom;
      md_enable = 1'($urandom_range(0, 1));
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL wrap_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      if (state === 2'd2) begin
        total++;
        if (m_tdata !== {NCH{DW'(ntr % 16)}}) begin bad++; $display("FAIL wrap_trailer n=%0d got=%h want=%0d", ntr, m_tdata[DW-1:0], ntr % 16); end
        ntr++;
      end
      next_cyc();
    end
    total++;
    if (ntr != 17) begin bad++; $display("FAIL wrap_count got=%0d want=17", ntr); end
  endtask
  task automatic test_reset_mid();
    int nbeats;
    logic done;
    md_enable = 1'b1; m_tready = '1; s_tvalid = 2'b01; s_meta_tvalid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      s_tdata = {$urandom, $urandom};
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL rmid_pre_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      next_cyc();
    end
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL rmid_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      total++;
      if (m_tvalid !== '0 || m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== '0 || s_tready !== '0) begin
        bad++; $display("FAIL rmid_zero c=%0d got vld=%b keep=%h want 0", c, m_tvalid, m_tkeep);
      end
      next_cyc();
    end
    resetn = 1'b1; nbeats = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL rmid_post_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      if (state === 2'd0 && m_tvalid[0] && m_tready[0]) nbeats++;
      if (state === 2'd2) begin
        done = 1'b1;
        total++;
        if (m_tdata !== '0 || nbeats != FB) begin bad++; $display("FAIL rmid_restart got data=%h beats=%0d want 0/%0d", m_tdata, nbeats, FB); end
      end
      next_cyc();
    end
    total++;
    if (!done) begin bad++; $display("FAIL rmid_timeout got no trailer want trailer within 20 cycles"); end
  endtask
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      resetn = $urandom_range(0, 99) != 0;
      md_enable = $urandom_range(0, 9) != 0;
      s_tvalid = NCH'($urandom);
      s_tdata = {$urandom, $urandom};
      s_meta_tdata = $urandom;
      s_meta_tvalid = 1'($urandom);
      m_tready = $urandom_range(0, 2) != 0 ? '1 : NCH'($urandom);
      eval_cyc();
      total++;
      if (obs_v() !== exp_v) begin bad++; $display("FAIL random_model c=%0d got=%h want=%h", c, obs_v(), exp_v); end
      next_cyc();
    end
  endtask
  initial begin
    test_reset();
    test_basic_frame();
    test_priority();
    test_no_meta();
    test_trailer_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
